// File: rtl/cpu_ram_responder.sv
// cpu_ram_responder
//   RAM-side responder for the CPU<->RAM word interface. It holds a word-addressed
//   on-chip array behind a fixed-latency, fully pipelined read path. A request is
//   accepted on every edge, so there is no backpressure.
//
//   Optional feature: define RAM_FAULT_EN to add the sticky ram_fault flag and to
//   range-check addresses. Without it, the upper address bits alias modulo the depth.
//
// Parameters
//   ADDR_W    word-index width; depth = 2**ADDR_W words (byte address bits [ADDR_W+1:2])
//   READ_LAT  cycles from an accepted read to ram_ready/ram_load (1..4)
//
// Ports
//   ram_clk    sole clock, rising edge
//   rst        synchronous active-high reset
//   ram_addr   byte address
//   ram_store  write data
//   ram_ren    read request, sampled every edge
//   ram_wen    write request, sampled every edge
//   ram_load   read data; holds the last read value
//   ram_ready  1-cycle strobe marking a completing read
//   ram_fault  sticky error flag (RAM_FAULT_EN only)
module cpu_ram_responder #(
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 1
) (
    input  logic        ram_clk,
    input  logic        rst,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_store,
    input  logic        ram_ren,
    input  logic        ram_wen,
    output logic [31:0] ram_load,
    output logic        ram_ready
`ifdef RAM_FAULT_EN
    ,
    output logic        ram_fault
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              rd_acc;
    logic              wr_acc;
    logic [31:0]       rd_word;

    assign idx = ram_addr[ADDR_W+1:2];

    // When a read and a write arrive together, the write wins and the read is dropped.
    assign rd_acc = ram_ren & ~ram_wen;

`ifdef RAM_FAULT_EN
    logic oor;
    logic unused_addr;

    assign oor         = |ram_addr[31:ADDR_W+2];
    assign wr_acc      = ram_wen & ~rst & ~oor;
    assign rd_word     = oor ? 32'h0 : mem[idx];
    assign unused_addr = 1'b0;

    always_ff @(posedge ram_clk) begin
        if (rst)
            ram_fault <= 1'b0;
        else if ((ram_ren | ram_wen) &
                 (oor | (|ram_addr[1:0]) | (ram_ren & ram_wen)))
            ram_fault <= 1'b1;
    end
`else
    logic unused_addr;

    assign wr_acc      = ram_wen & ~rst;
    assign rd_word     = mem[idx];
    // The upper and byte-lane address bits are intentionally ignored (aliasing).
    assign unused_addr = ^{ram_addr[31:ADDR_W+2], ram_addr[1:0]};
`endif

    // The array has no reset: its contents survive rst.
    always_ff @(posedge ram_clk) begin
        if (wr_acc)
            mem[idx] <= ram_store;
    end

    // Read pipeline. Stage 0 captures the array word at the acceptance edge. Later
    // stages only forward what stage 0 captured and never re-read the array. Each data
    // stage advances only behind a valid bit, so the last stage (ram_load) holds
    // between reads.
    logic [READ_LAT-1:0]       vld_pipe;
    logic [READ_LAT-1:0][31:0] dat_pipe;

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            if (rd_acc)
                dat_pipe[0] <= rd_word;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1])
                    dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign ram_ready = vld_pipe[READ_LAT-1];
    assign ram_load  = dat_pipe[READ_LAT-1];

endmodule

// File: tb/tb_cpu_ram_responder.sv
// Testbench for cpu_ram_responder. It uses randomized traffic, checks every cycle
// against a queue-based reference model, and adds literal checks for the directed
// scenarios. It also covers the RAM_FAULT_EN build when that macro is defined.
module tb_cpu_ram_responder;

    localparam int AW = 12;
    localparam int RL = 3;
    localparam int WIN = 64;   // random traffic stays inside the first WIN preloaded words

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] store = '0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] load;
    logic        ready;
`ifdef RAM_FAULT_EN
    logic        fault;
    localparam bit FEN = 1'b1;
`else
    logic        fault;
    localparam bit FEN = 1'b0;
    assign fault = 1'b0;
`endif

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    cpu_ram_responder #(.ADDR_W(AW), .READ_LAT(RL)) dut (
        .ram_clk  (clk),
        .rst      (rst),
        .ram_addr (addr),
        .ram_store(store),
        .ram_ren  (ren),
        .ram_wen  (wen),
        .ram_load (load),
        .ram_ready(ready)
`ifdef RAM_FAULT_EN
        ,
        .ram_fault(fault)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct { longint due; logic [31:0] data; } resp_t;
    resp_t       pend[$];
    logic [31:0] mm [1 << AW];
    longint      edge_no = 0;
    logic        exp_ready = 1'b0;
    logic [31:0] exp_load = '0;
    logic        exp_fault = 1'b0;

    initial forever begin
        @(posedge clk);
        begin
            int unsigned wi;
            bit          oor;
            resp_t       r;
            wi  = addr[AW+1:2];
            oor = FEN && (addr >> (AW + 2)) != 0;
            if (rst) begin
                pend.delete();
                exp_load  = '0;
                exp_fault = 1'b0;
            end else begin
                if (ren && !wen) begin
                    r.due  = edge_no + RL - 1;
                    r.data = oor ? 32'h0 : mm[wi];
                    pend.push_back(r);
                end
                if (wen && !oor) mm[wi] = store;
                if (FEN && (ren || wen) && (oor || addr[1:0] != 0 || (ren && wen)))
                    exp_fault = 1'b1;
            end
            exp_ready = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_no) begin
                exp_ready = 1'b1;
                exp_load  = pend[0].data;
                void'(pend.pop_front());
            end
            edge_no++;
        end
    end

    // ---------------- per-cycle compare ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("ready", {31'h0, ready}, {31'h0, exp_ready});
            check("load", load, exp_load);
            if (FEN) check("fault", {31'h0, fault}, {31'h0, exp_fault});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic rn, input logic wn,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r; ren = rn; wen = wn; addr = a; store = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Issue one read, then check the literal result once its latency has elapsed.
    task automatic read_lit(input string name, input logic [31:0] a, input logic [31:0] v);
        cyc(1'b0, 1'b1, 1'b0, a, 32'h0);
        for (int i = 0; i < RL - 1; i++) idle();
        check({name, "_rdy"}, {31'h0, ready}, 32'h1);
        check(name, load, v);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_en = 1'b1;
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_load", load, 32'h0);

        // Preload the window so every random read hits a known word.
        for (int i = 0; i < WIN; i++) cyc(1'b0, 1'b0, 1'b1, i * 4, $urandom);

        // Write, then read the same word on the next cycle.
        cyc(1'b0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
        read_lit("wr_then_rd", 32'h10, 32'hCAFEF00D);

        // Four back-to-back reads must produce four back-to-back strobes, in order.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, i * 4, i + 1);
        for (int k = 0; k < 4 + RL - 1; k++) begin
            if (k < 4) cyc(1'b0, 1'b1, 1'b0, k * 4, 32'h0);
            else idle();
            if (k >= RL - 1) begin
                check("b2b_rdy", {31'h0, ready}, 32'h1);
                check("b2b_data", load, k - (RL - 1) + 1);
            end
        end

        // A simultaneous read and write performs the write and drops the read.
        cyc(1'b0, 1'b1, 1'b1, 32'h20, 32'h5A5A5A5A);
        for (int i = 0; i < RL + 1; i++) begin
            idle();
            check("rw_no_rdy", {31'h0, ready}, 32'h0);
        end
        read_lit("rw_wrote", 32'h20, 32'h5A5A5A5A);

        // Reset with two reads in flight: both are dropped and the array is kept.
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("midrst_load", load, 32'h0);
        for (int i = 0; i < RL + 1; i++) begin
            idle();
            check("midrst_no_rdy", {31'h0, ready}, 32'h0);
        end
        read_lit("midrst_mem", 32'h4, 32'h2);

`ifdef RAM_FAULT_EN
        // An out-of-range write raises the flag and does not alias onto word 0.
        cyc(1'b0, 1'b0, 1'b1, 32'h0, 32'h11);
        check("flt_clear", {31'h0, fault}, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'h1);
        check("flt_set", {31'h0, fault}, 32'h1);
        read_lit("flt_noalias", 32'h0, 32'h11);
        check("flt_sticky", {31'h0, fault}, 32'h1);
        read_lit("flt_oor_rd", 32'h0000_4000, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("flt_rst", {31'h0, fault}, 32'h0);
`else
        // The upper address bits alias modulo the depth.
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_4004, 32'h77);
        read_lit("alias", 32'h4, 32'h77);
`endif

        // Randomized traffic, with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            logic        r, rn, wn;
            a  = $urandom_range(0, WIN - 1) * 4;
            r  = ($urandom_range(0, 39) == 0);
            rn = $urandom_range(0, 1);
            wn = ($urandom_range(0, 2) == 0);
            if (FEN) begin
                if ($urandom_range(0, 19) == 0) a[1:0] = $urandom_range(0, 3);
                if ($urandom_range(0, 19) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
            end else begin
                a = a | ($urandom & 32'hFFFF_C003);
            end
            cyc(r, rn, wn, a, $urandom);
        end
        for (int i = 0; i < RL + 2; i++) idle();

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
